// File: rtl/run_ctrl.sv
// run_ctrl: debug run/step/breakpoint controller that issues CPU start/stop pulses.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   init_calib_complete     memory calibration done
//   cmd_valid/cmd_ready     command handshake; cmd_op 00 RUN, 01 STOP, 10 STEP, 11 SETBP
//   cmd_adr, cmd_cnt        start/breakpoint address, step count (bit0 = bp enable on SETBP)
//   pc_id, pc_valid_id      ID-stage PC and valid; stall blocks retirement
//   cpu_run_state           CPU running status; cpu_stopping CPU still winding down
//   cpu_start, start_adr    one-cycle start pulse and its address
//   quit_cmd                one-cycle stop pulse
//   bp_hit                  last stop came from the breakpoint (sticky)
//   instr_cnt               retired instructions since the last start
//   ctrl_state              FSM state code
module run_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        init_calib_complete,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:2] cmd_adr,
   input  logic [15:0] cmd_cnt,
   input  logic [31:2] pc_id,
   input  logic        pc_valid_id,
   input  logic        stall,
   input  logic        cpu_run_state,
   input  logic        cpu_stopping,
   output logic        cpu_start,
   output logic [31:2] start_adr,
   output logic        quit_cmd,
   output logic        bp_hit,
   output logic [31:0] instr_cnt,
   output logic [2:0]  ctrl_state
);
   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd1, S_RUN = 3'd2, S_STEP = 3'd3, S_STOP = 3'd4;
   logic [2:0]  state, state_nxt;
   logic        start_nxt, quit_nxt;
   logic        rdy, dw, lo, pend_step, bp_en;
   logic [31:2] bp_adr;
   logic [15:0] step_cnt;
   logic        acc, ret, is_go, op_stop, op_step, run_like, bp_match, stop_any, abort, go_acc;
   assign acc      = cmd_valid & cmd_ready;
   assign ret      = pc_valid_id & ~stall;
   assign is_go    = ~cmd_op[0];
   assign op_step  = cmd_op == 2'b10;
   assign op_stop  = cmd_op == 2'b01;
   assign run_like = (state == S_RUN) | (state == S_STEP);
   assign bp_match = ret & bp_en & (pc_id == bp_adr);
   assign stop_any = (acc & op_stop) | bp_match | ((state == S_STEP) & ret & (step_cnt == 16'd1));
   // Lost calibration or a CPU that never reports running abandons the run silently.
   assign abort    = ~init_calib_complete | (~cpu_start & ~cpu_run_state & lo);
   assign go_acc   = acc & is_go & (state == S_IDLE);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= S_IDLE;
      else state <= state_nxt;
   always_comb begin
      state_nxt = S_IDLE;
      start_nxt = 1'b0;
      quit_nxt  = 1'b0;
      case (state)
         S_IDLE: begin
            state_nxt = go_acc ? (init_calib_complete ? (op_step ? S_STEP : S_RUN) : S_WAIT) : S_IDLE;
            start_nxt = go_acc & init_calib_complete;
         end
         S_WAIT: begin
            state_nxt = (acc & op_stop) ? S_IDLE : init_calib_complete ? (pend_step ? S_STEP : S_RUN) : S_WAIT;
            start_nxt = ~(acc & op_stop) & init_calib_complete;
         end
         S_RUN, S_STEP: begin
            state_nxt = abort ? S_IDLE : stop_any ? S_STOP : state;
            quit_nxt  = ~abort & stop_any;
         end
         S_STOP: state_nxt = (dw & ~cpu_stopping) ? S_IDLE : S_STOP;
         default: state_nxt = S_IDLE;
      endcase
   end
   always_comb begin
      cmd_ready  = rdy & (state != S_STOP);
      ctrl_state = state;
   end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         rdy       <= 1'b0;
         cpu_start <= 1'b0;
         quit_cmd  <= 1'b0;
         dw        <= 1'b0;
         lo        <= 1'b0;
         pend_step <= 1'b0;
         bp_en     <= 1'b0;
         bp_adr    <= '0;
         start_adr <= '0;
         step_cnt  <= '0;
         instr_cnt <= '0;
         bp_hit    <= 1'b0;
      end else begin
         rdy       <= 1'b1;
         cpu_start <= start_nxt;
         quit_cmd  <= quit_nxt;
         // dw marks that STOPPING has already lasted one cycle; lo marks one low run-state cycle.
         dw        <= state == S_STOP;
         lo        <= run_like & ~cpu_start & ~cpu_run_state;
         if (acc & (cmd_op == 2'b11)) begin
            bp_adr <= cmd_adr;
            bp_en  <= cmd_cnt[0];
         end
         if (go_acc) begin
            start_adr <= cmd_adr;
            pend_step <= op_step;
         end
         if (go_acc & op_step) step_cnt <= (cmd_cnt == 16'd0) ? 16'd1 : cmd_cnt;
         else if ((state == S_STEP) & ret & ~stop_any) step_cnt <= step_cnt - 16'd1;
         if (start_nxt) begin
            instr_cnt <= '0;
            bp_hit    <= 1'b0;
         end else begin
            if (run_like & ret) instr_cnt <= instr_cnt + 32'd1;
            if (run_like & ~abort & bp_match) bp_hit <= 1'b1;
         end
      end
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: directed self-checking bench for run_ctrl.
module tb_run_ctrl;
   logic        clk = 1'b0, rst_n = 1'b0, init_calib_complete = 1'b1, cmd_valid = 1'b0, cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [31:2] cmd_adr = '0, pc_id = '0, start_adr;
   logic [15:0] cmd_cnt = '0;
   logic        pc_valid_id = 1'b0, stall = 1'b0, cpu_run_state = 1'b1, cpu_stopping = 1'b0;
   logic        cpu_start, quit_cmd, bp_hit;
   logic [31:0] instr_cnt;
   logic [2:0]  ctrl_state;
   int checks = 0, errors = 0, np;

   run_ctrl dut (
      .clk(clk), .rst_n(rst_n), .init_calib_complete(init_calib_complete),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_adr(cmd_adr),
      .cmd_cnt(cmd_cnt), .pc_id(pc_id), .pc_valid_id(pc_valid_id), .stall(stall),
      .cpu_run_state(cpu_run_state), .cpu_stopping(cpu_stopping), .cpu_start(cpu_start),
      .start_adr(start_adr), .quit_cmd(quit_cmd), .bp_hit(bp_hit), .instr_cnt(instr_cnt),
      .ctrl_state(ctrl_state)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic [1:0] op, input logic [29:0] adr, input logic [15:0] cnt);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_adr   = adr;
      cmd_cnt   = cnt;
      tick();
      cmd_valid = 1'b0;
   endtask

   task automatic test_reset();
      tick();
      tick();
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", cmd_ready); end
      checks++; if (ctrl_state !== 3'd0) begin errors++; $display("FAIL rst_state: got %0d want 0", ctrl_state); end
      checks++; if ({cpu_start, quit_cmd, bp_hit} !== 3'b000 || instr_cnt !== 32'd0 || start_adr !== 30'd0) begin errors++; $display("FAIL rst_outs: got %b/%0h/%0h want 0", {cpu_start, quit_cmd, bp_hit}, instr_cnt, start_adr); end
      rst_n = 1'b1;
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL rel_ready_pre: got %0b want 0", cmd_ready); end
      tick();
      checks++; if (cmd_ready !== 1'b1) begin errors++; $display("FAIL rel_ready: got %0b want 1", cmd_ready); end
   endtask

   task automatic test_run();
      cmd(2'b00, 30'h100, 16'd0);
      checks++; if (cpu_start !== 1'b1) begin errors++; $display("FAIL run_start: got %0b want 1", cpu_start); end
      checks++; if (start_adr !== 30'h100) begin errors++; $display("FAIL run_adr: got %0h want 100", start_adr); end
      checks++; if (ctrl_state !== 3'd2) begin errors++; $display("FAIL run_state: got %0d want 2", ctrl_state); end
      pc_valid_id = 1'b1;
      repeat (5) tick();
      pc_valid_id = 1'b0;
      checks++; if (instr_cnt !== 32'd5) begin errors++; $display("FAIL run_cnt: got %0d want 5", instr_cnt); end
      checks++; if (cpu_start !== 1'b0) begin errors++; $display("FAIL run_start_off: got %0b want 0", cpu_start); end
      pc_valid_id = 1'b1;
      stall = 1'b1;
      tick();
      pc_valid_id = 1'b0;
      stall = 1'b0;
      checks++; if (instr_cnt !== 32'd5) begin errors++; $display("FAIL run_stall: got %0d want 5", instr_cnt); end
      cmd(2'b01, 30'h0, 16'd0);
      checks++; if (quit_cmd !== 1'b1 || ctrl_state !== 3'd4) begin errors++; $display("FAIL run_stop: got q=%0b s=%0d want q=1 s=4", quit_cmd, ctrl_state); end
      checks++; if (cmd_ready !== 1'b0) begin errors++; $display("FAIL stop_ready: got %0b want 0", cmd_ready); end
      tick();
      checks++; if (quit_cmd !== 1'b0 || ctrl_state !== 3'd4) begin errors++; $display("FAIL stop_dwell: got q=%0b s=%0d want q=0 s=4", quit_cmd, ctrl_state); end
      tick();
      checks++; if (ctrl_state !== 3'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL stop_exit: got s=%0d r=%0b want s=0 r=1", ctrl_state, cmd_ready); end
   endtask

   task automatic test_calib();
      init_calib_complete = 1'b0;
      cmd(2'b01, 30'h0, 16'd0);
      checks++; if (ctrl_state !== 3'd0 || quit_cmd !== 1'b0) begin errors++; $display("FAIL idle_stop: got s=%0d q=%0b want s=0 q=0", ctrl_state, quit_cmd); end
      cmd(2'b00, 30'h55, 16'd0);
      checks++; if (ctrl_state !== 3'd1 || cpu_start !== 1'b0) begin errors++; $display("FAIL wait_enter: got s=%0d st=%0b want s=1 st=0", ctrl_state, cpu_start); end
      cmd(2'b00, 30'h77, 16'd0);
      np = 0;
      repeat (8) begin tick(); np += int'(cpu_start); end
      init_calib_complete = 1'b1;
      tick();
      checks++; if (cpu_start !== 1'b1 || ctrl_state !== 3'd2 || np != 0) begin errors++; $display("FAIL calib_start: got st=%0b s=%0d early=%0d want st=1 s=2 early=0", cpu_start, ctrl_state, np); end
      checks++; if (start_adr !== 30'h55) begin errors++; $display("FAIL calib_adr: got %0h want 55", start_adr); end
      np = int'(cpu_start);
      repeat (3) begin tick(); np += int'(cpu_start); end
      checks++; if (np != 1) begin errors++; $display("FAIL calib_once: got %0d pulses want 1", np); end
      init_calib_complete = 1'b0;
      tick();
      checks++; if (ctrl_state !== 3'd0 || quit_cmd !== 1'b0) begin errors++; $display("FAIL calib_loss: got s=%0d q=%0b want s=0 q=0", ctrl_state, quit_cmd); end
      cmd(2'b10, 30'h9, 16'd2);
      cmd(2'b01, 30'h0, 16'd0);
      init_calib_complete = 1'b1;
      tick();
      checks++; if (ctrl_state !== 3'd0 || cpu_start !== 1'b0 || quit_cmd !== 1'b0) begin errors++; $display("FAIL wait_stop: got s=%0d st=%0b q=%0b want 0/0/0", ctrl_state, cpu_start, quit_cmd); end
   endtask

   task automatic test_step();
      cmd(2'b10, 30'h200, 16'd3);
      checks++; if (cpu_start !== 1'b1 || ctrl_state !== 3'd3) begin errors++; $display("FAIL step_start: got st=%0b s=%0d want st=1 s=3", cpu_start, ctrl_state); end
      pc_valid_id = 1'b1;
      tick();
      tick();
      checks++; if (quit_cmd !== 1'b0 || ctrl_state !== 3'd3) begin errors++; $display("FAIL step_mid: got q=%0b s=%0d want q=0 s=3", quit_cmd, ctrl_state); end
      tick();
      pc_valid_id = 1'b0;
      cpu_stopping = 1'b1;
      checks++; if (quit_cmd !== 1'b1 || ctrl_state !== 3'd4 || instr_cnt !== 32'd3) begin errors++; $display("FAIL step_quit: got q=%0b s=%0d n=%0d want q=1 s=4 n=3", quit_cmd, ctrl_state, instr_cnt); end
      repeat (3) tick();
      checks++; if (quit_cmd !== 1'b0 || ctrl_state !== 3'd4) begin errors++; $display("FAIL step_hold: got q=%0b s=%0d want q=0 s=4", quit_cmd, ctrl_state); end
      cpu_stopping = 1'b0;
      tick();
      checks++; if (ctrl_state !== 3'd0) begin errors++; $display("FAIL step_exit: got s=%0d want 0", ctrl_state); end
      cmd(2'b10, 30'h10, 16'd0);
      pc_valid_id = 1'b1;
      tick();
      pc_valid_id = 1'b0;
      checks++; if (quit_cmd !== 1'b1 || instr_cnt !== 32'd1) begin errors++; $display("FAIL step_zero: got q=%0b n=%0d want q=1 n=1", quit_cmd, instr_cnt); end
      tick();
      tick();
   endtask

   task automatic test_breakpoint();
      cmd(2'b11, 30'h40, 16'd1);
      checks++; if (ctrl_state !== 3'd0 || cpu_start !== 1'b0) begin errors++; $display("FAIL setbp: got s=%0d st=%0b want s=0 st=0", ctrl_state, cpu_start); end
      cmd(2'b00, 30'h0, 16'd0);
      pc_valid_id = 1'b1;
      pc_id = 30'h10;
      tick();
      checks++; if (quit_cmd !== 1'b0 || instr_cnt !== 32'd1) begin errors++; $display("FAIL bp_miss: got q=%0b n=%0d want q=0 n=1", quit_cmd, instr_cnt); end
      pc_id = 30'h40;
      tick();
      pc_valid_id = 1'b0;
      checks++; if (quit_cmd !== 1'b1 || bp_hit !== 1'b1 || ctrl_state !== 3'd4) begin errors++; $display("FAIL bp_hit: got q=%0b h=%0b s=%0d want q=1 h=1 s=4", quit_cmd, bp_hit, ctrl_state); end
      tick();
      tick();
      checks++; if (ctrl_state !== 3'd0 || bp_hit !== 1'b1) begin errors++; $display("FAIL bp_sticky: got s=%0d h=%0b want s=0 h=1", ctrl_state, bp_hit); end
   endtask

   task automatic test_back_to_back();
      cmd(2'b00, 30'h8, 16'd0);
      checks++; if (cpu_start !== 1'b1 || bp_hit !== 1'b0) begin errors++; $display("FAIL b2b_start: got st=%0b h=%0b want st=1 h=0", cpu_start, bp_hit); end
      pc_valid_id = 1'b1;
      pc_id = 30'h40;
      cmd(2'b01, 30'h0, 16'd0);
      pc_valid_id = 1'b0;
      checks++; if (quit_cmd !== 1'b1 || bp_hit !== 1'b1) begin errors++; $display("FAIL b2b_quit: got q=%0b h=%0b want q=1 h=1", quit_cmd, bp_hit); end
      np = 0;
      repeat (3) begin tick(); np += int'(quit_cmd); end
      checks++; if (np != 0 || ctrl_state !== 3'd0) begin errors++; $display("FAIL b2b_once: got extra=%0d s=%0d want extra=0 s=0", np, ctrl_state); end
      cmd(2'b11, 30'h40, 16'd0);
      cmd(2'b00, 30'h0, 16'd0);
      pc_valid_id = 1'b1;
      tick();
      pc_valid_id = 1'b0;
      checks++; if (quit_cmd !== 1'b0 || ctrl_state !== 3'd2) begin errors++; $display("FAIL bp_disabled: got q=%0b s=%0d want q=0 s=2", quit_cmd, ctrl_state); end
      cpu_run_state = 1'b0;
      tick();
      checks++; if (ctrl_state !== 3'd2) begin errors++; $display("FAIL runst_one: got s=%0d want 2", ctrl_state); end
      tick();
      cpu_run_state = 1'b1;
      checks++; if (ctrl_state !== 3'd0 || quit_cmd !== 1'b0) begin errors++; $display("FAIL runst_abort: got s=%0d q=%0b want s=0 q=0", ctrl_state, quit_cmd); end
   endtask

   task automatic test_reset_mid();
      cmd(2'b11, 30'h40, 16'd1);
      cmd(2'b10, 30'h300, 16'd5);
      pc_valid_id = 1'b1;
      tick();
      tick();
      #2 rst_n = 1'b0;
      #1;
      pc_valid_id = 1'b0;
      checks++; if (ctrl_state !== 3'd0 || cmd_ready !== 1'b0) begin errors++; $display("FAIL mid_state: got s=%0d r=%0b want s=0 r=0", ctrl_state, cmd_ready); end
      checks++; if ({cpu_start, quit_cmd, bp_hit} !== 3'b000 || instr_cnt !== 32'd0 || start_adr !== 30'd0) begin errors++; $display("FAIL mid_outs: got %b/%0h/%0h want 0", {cpu_start, quit_cmd, bp_hit}, instr_cnt, start_adr); end
      tick();
      rst_n = 1'b1;
      np = 0;
      repeat (5) begin tick(); np += int'(cpu_start) + int'(quit_cmd); end
      checks++; if (np != 0 || ctrl_state !== 3'd0 || cmd_ready !== 1'b1) begin errors++; $display("FAIL mid_release: got pulses=%0d s=%0d r=%0b want 0/0/1", np, ctrl_state, cmd_ready); end
      cmd(2'b00, 30'h0, 16'd0);
      pc_valid_id = 1'b1;
      pc_id = 30'h40;
      tick();
      pc_valid_id = 1'b0;
      checks++; if (quit_cmd !== 1'b0) begin errors++; $display("FAIL mid_bp_clear: got q=%0b want 0", quit_cmd); end
   endtask

   initial begin
      test_reset();
      test_run();
      test_calib();
      test_step();
      test_breakpoint();
      test_back_to_back();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
